sha256_msg_schedule: RTL and testbench

//  Message-schedule sequencer for one SHA-256 compression. Latches a 512-bit

---
 rtl/sha256_msg_schedule_pkg.sv | 27 ++
 rtl/sha256_new_block.sv | 14 +
 rtl/sha256_msg_schedule.sv | 103 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_schedule_pkg.sv
// Shared types and the SHA-256 small-sigma helpers used by the message schedule.
package sha256_msg_schedule_pkg;

  localparam int WORD_W      = 32;
  localparam int SCHED_WORDS = 64;
  localparam int WIN_WORDS   = 16;
  localparam int BLOCK_W     = WORD_W * WIN_WORDS;
  localparam int IDX_W       = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_new_block.sv
// Combinational schedule expansion: y = s0(a) + s1(b) + c + d, mod 2^32.
module sha256_new_block
  import sha256_msg_schedule_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t y
);

  assign y = small_sigma0(a) + small_sigma1(b) + c + d;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule sequencer: latches a padded block and streams
// W[0..NUM_ROUNDS-1] over a valid/ready handshake from a 16-word sliding window.
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
#(
  parameter int NUM_ROUNDS = SCHED_WORDS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic               w_ready,
  output logic               w_valid,
  output logic [WORD_W-1:0]  w_out,
  output logic [IDX_W-1:0]   w_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(NUM_ROUNDS - 1);

  sched_state_t     state_q, state_d;
  word_t            win_q [WIN_WORDS];
  word_t            win_d [WIN_WORDS];
  logic [IDX_W-1:0] t_q, t_d;
  logic             w_valid_q, w_valid_d;
  logic             done_q, done_d;
  logic             hs;
  word_t            w_next;

  // Window holds W[t..t+15]; the word 16 ahead is W[t+16] from W[t+1], W[t+14], W[t], W[t+9].
  sha256_new_block u_new_block (
    .a (win_q[1]),
    .b (win_q[14]),
    .c (win_q[0]),
    .d (win_q[9]),
    .y (w_next)
  );

  assign hs = w_valid_q & w_ready;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          for (int k = 0; k < WIN_WORDS; k++) begin
            win_d[k] = block_in[BLOCK_W-1-WORD_W*k -: WORD_W];
          end
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort outranks a same-cycle handshake
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          for (int k = 0; k < WIN_WORDS-1; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[WIN_WORDS-1] = w_next;
          t_d                = t_q + IDX_W'(1);
          if (t_q == LAST_T) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    w_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      t_q       <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < WIN_WORDS; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
      win_q     <= win_d;
    end
  end

  assign w_valid = w_valid_q;
  assign w_out   = win_q[0];
  assign w_idx   = t_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: reference schedule pushed to a queue at start,
// popped and compared on every handshake.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         abort;
  logic [511:0] block_in;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         busy;
  logic         done;

  sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .block_in (block_in),
    .w_ready  (w_ready),
    .w_valid  (w_valid),
    .w_out    (w_out),
    .w_idx    (w_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  bit abc_consts = 1'b0;

  logic [511:0] blk_abc;
  logic [511:0] blk_b;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [511:0] blk);
    logic [31:0] w[64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.w   = w[t];
      e.idx = 6'(t);
      sb.push_back(e);
    end
  endtask

  // Called in a cycle where w_valid & w_ready will handshake at the next edge.
  task automatic pop_check();
    exp_t e;
    hs_cnt++;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("w_out", w_out, e.w);
      check("w_idx", 32'(w_idx), 32'(e.idx));
      if (abc_consts && e.idx == 6'd16) check("abc_w16", w_out, 32'h61626380);
      if (abc_consts && e.idx == 6'd17) check("abc_w17", w_out, 32'h000F0000);
      if (abc_consts && e.idx == 6'd63) check("abc_w63", w_out, 32'h12B1EDEB);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve the round-stage side until done; returns the cycle index of done,
  // counting the first-word cycle as 1.
  task automatic serve(input bit rnd, output int cyc);
    logic [31:0] pw;
    logic [5:0]  pi;
    bit          stalled;
    cyc = 1;
    stalled = 1'b0;
    pw = '0;
    pi = '0;
    while (done !== 1'b1 && cyc < 400) begin
      if (stalled) begin
        check("stall_w_out", w_out, pw);
        check("stall_w_idx", 32'(w_idx), 32'(pi));
      end
      check("valid_mid_block", 32'(w_valid), 32'd1);
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid && w_ready) begin
        pop_check();
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pw = w_out;
        pi = w_idx;
      end
      step();
      cyc++;
    end
    w_ready = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("done_valid_low", 32'(w_valid), 32'd0);
    check("done_busy_low", 32'(busy), 32'd0);
  endtask

  // Handshake words until w_idx reaches target; leaves w_ready low, no edge taken.
  task automatic advance_to(input logic [5:0] target);
    int n;
    n = 0;
    while (!(w_valid && w_idx == target) && n < 200) begin
      w_ready = 1'b1;
      if (w_valid) pop_check();
      step();
      n++;
    end
    w_ready = 1'b0;
    check("advance_idx", 32'(w_idx), 32'(target));
  endtask

  initial begin
    int cyc;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    w_ready  = 1'b0;
    blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
    for (int k = 0; k < 16; k++) blk_b[511-32*k -: 32] = (32'h01010101 * k) ^ 32'hDEADBEEF;
    block_in = blk_abc;

    // reset state
    step();
    step();
    check("rst_valid", 32'(w_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(w_idx), 32'd0);
    check("rst_w_out", w_out, 32'd0);
    reset_n = 1'b1;
    step();
    check("idle_valid", 32'(w_valid), 32'd0);

    // 1) abc block, w_ready always high
    abc_consts = 1'b1;
    hs_cnt = 0;
    push_block(blk_abc);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    serve(1'b0, cyc);
    check("t1_latency", 32'(cyc), 32'd65);
    check("t1_hs", 32'(hs_cnt), 32'd64);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    step();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(w_valid), 32'd0);

    // 2) random back-pressure
    hs_cnt = 0;
    push_block(blk_abc);
    start = 1'b1;
    step();
    start = 1'b0;
    serve(1'b1, cyc);
    check("t2_hs", 32'(hs_cnt), 32'd64);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // 3) abort at w_idx 20 while w_ready high
    abc_consts = 1'b0;
    push_block(blk_b);
    block_in = blk_b;
    start = 1'b1;
    step();
    start = 1'b0;
    advance_to(6'd20);
    abort = 1'b1;
    w_ready = 1'b1;
    step();
    abort = 1'b0;
    w_ready = 1'b0;
    check("t3_valid", 32'(w_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    step();
    check("t3_done_later", 32'(done), 32'd0);
    sb.delete();
    hs_cnt = 0;
    push_block(blk_b);
    start = 1'b1;
    step();
    start = 1'b0;
    serve(1'b0, cyc);
    check("t3_rerun_lat", 32'(cyc), 32'd65);
    check("t3_rerun_hs", 32'(hs_cnt), 32'd64);
    step();

    // abort + start in IDLE: abort wins
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("idle_abort_start", 32'(w_valid), 32'd0);
    step();

    // 4) start mid-block with a different block is ignored
    abc_consts = 1'b1;
    hs_cnt = 0;
    push_block(blk_abc);
    block_in = blk_abc;
    start = 1'b1;
    step();
    start = 1'b0;
    advance_to(6'd10);
    w_ready = 1'b1;
    pop_check();
    start = 1'b1;
    block_in = blk_b;
    step();
    start = 1'b0;
    block_in = blk_abc;
    serve(1'b0, cyc);
    check("t4_hs", 32'(hs_cnt), 32'd64);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    step();

    // 5) asynchronous reset mid-block
    push_block(blk_abc);
    start = 1'b1;
    step();
    start = 1'b0;
    advance_to(6'd30);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_valid", 32'(w_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    sb.delete();
    step();
    reset_n = 1'b1;
    step();
    step();
    check("t5_idle_valid", 32'(w_valid), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_done", 32'(done), 32'd0);

    // 6) back-to-back blocks with start held high
    hs_cnt = 0;
    push_block(blk_abc);
    block_in = blk_abc;
    start = 1'b1;
    step();
    block_in = blk_b;
    serve(1'b0, cyc);
    check("t6_first_lat", 32'(cyc), 32'd65);
    abc_consts = 1'b0;
    push_block(blk_b);
    step();
    start = 1'b0;
    check("t6_next_valid", 32'(w_valid), 32'd1);
    check("t6_next_idx", 32'(w_idx), 32'd0);
    check("t6_next_w0", w_out, blk_b[511:480]);
    serve(1'b0, cyc);
    check("t6_second_lat", 32'(cyc), 32'd65);
    check("t6_hs", 32'(hs_cnt), 32'd128);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    step();
    check("t6_final_idle", 32'(w_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
